water_tap_scheduler: RTL
========================

# water_tap_scheduler

Shares one supply pump among several touchless taps, each with its own IR presence sensor and solenoid relay. The block synchronises and debounces every IR input and grants the pump to one tap at a time in round-robin order. It enforces a maximum dispense time per grant and a cool-down gap between grants. It sits between the raw IR sensor pins and the relay/pump drivers, and replaces per-tap direct IR-to-relay control when taps share a supply.

## Interface
- N_TAPS, 4: number of taps, 2..8.
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to change a debounced request, ≥2.
- MAX_ON_CYCLES, 16: maximum cycles one grant may hold the relay on.
- COOLDOWN_CYCLES, 4: cycles with all relays and the pump off between grants, ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ir_pin  in  N_TAPS  raw IR presence per tap, asynchronous, 1 = hand present.
- relay_out  out  N_TAPS  solenoid drive, one-hot or zero.
- pump_on  out  1  shared pump drive; high exactly when relay_out is non-zero.
- active_id  out  $clog2(N_TAPS)  index of granted tap; 0 when idle.
- timeout_pulse  out  1  one-cycle pulse when a grant ends by MAX_ON_CYCLES.

## Operation
- Per tap: a 2-flop synchroniser feeds the debouncer.
- Debouncer: counter increments while the synchronised value ≠ req[i] and resets when they match. On the DEBOUNCE_CYCLES-th consecutive differing sample, req[i] takes the new value and the counter clears. Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Eligibility: eligible[i] = req[i] & ~lockout[i].
- lockout[i] is set when tap i's grant times out and cleared when req[i] falls. A hand held past timeout therefore gets no second grant until it is removed.
- FSM states: IDLE, OPEN, COOLDOWN.
- IDLE → OPEN when any tap is eligible. Grant the first eligible tap searching upward from last_grant+1 modulo N_TAPS, then update last_grant. relay_out[g] and pump_on go high, active_id = g, and the on-counter loads 1.
- OPEN → COOLDOWN when req[g] falls (normal release) or the on-counter reaches MAX_ON_CYCLES (timeout). On timeout, set lockout[g] and pulse timeout_pulse. In both cases all relays and the pump go off.
- COOLDOWN → IDLE after exactly COOLDOWN_CYCLES cycles. Requests arriving during OPEN or COOLDOWN wait; no request is lost while its req stays high.
- last_grant resets to N_TAPS-1, so tap 0 has first priority after reset.

## Timing
- Reset values: relay_out = 0, pump_on = 0, active_id = 0, timeout_pulse = 0, state IDLE, all req/lockout/counters 0, last_grant = N_TAPS-1.
- ir_pin change captured at edge E: req changes after edge E+1+DEBOUNCE_CYCLES. With the scheduler idle, relay_out rises after edge E+2+DEBOUNCE_CYCLES (6 cycles at defaults).
- Release latency: ir_pin fall to relay_out fall is 2+DEBOUNCE_CYCLES cycles.
- A grant holds relay_out high for at most MAX_ON_CYCLES cycles.
- timeout_pulse is high for the first COOLDOWN cycle only.
- Between grants there are exactly COOLDOWN_CYCLES cycles with all outputs off, then 1 IDLE cycle, so the next relay rises at least COOLDOWN_CYCLES+1 cycles after the previous one falls.
- Simultaneous req edges on multiple taps: resolved solely by the round-robin pointer.
- A req that falls in the same cycle as the timeout counts as a timeout (lockout set, then cleared the next cycle because req is low).
- Reset asserted mid-grant: relay_out and pump_on drop asynchronously, with no cool-down.
- relay_out, pump_on, active_id and timeout_pulse are all registered, with no combinational path from ir_pin.

## Structure
- Package water_tap_pkg holds the state enum (IDLE/OPEN/COOLDOWN) and the default parameter constants.
- Sub-module ir_debounce holds one tap's synchroniser plus debounce counter, with ports clk, reset, ir_pin, req. It is instantiated N_TAPS times by a generate loop.
- The top level holds the FSM, round-robin selector, on/cool-down counter (shared) and lockout register.

## Test plan
All scenarios use the defaults and a 20 ns clock.
- Reset then idle: assert reset for 100 ns with ir_pin = 0 → all outputs 0 and no grant for 50 cycles.
- Single tap: ir_pin[0] = 1 for 10 cycles, then 0 → relay_out = 0001 after 6 cycles, pump_on tracks it, relay falls 6 cycles after the ir fall, then 4 cycles of cool-down.
- Glitch reject: 3-cycle pulse on ir_pin[2] → relay_out stays 0000.
- Round robin: ir_pin = 1111 held → grants to taps 0,1,2,3,0 in that order. Each grant lasts 16 cycles with a timeout_pulse. Because of lockout, the second grant to tap 0 occurs only after ir_pin[0] drops and rises again.
- Timeout and lockout: ir_pin[1] held for 40 cycles → relay on 16 cycles, timeout_pulse once, no regrant. Drop ir_pin[1] and raise it again → new grant.
- Reset mid-grant: assert reset 5 cycles into a grant → relay_out and pump_on are 0 within the same cycle. After release, tap 0 has first priority again.

Source files
------------

// File: rtl/water_tap_pkg.sv
// Shared types and default sizing for the water tap pump scheduler.
package water_tap_pkg;

  localparam int unsigned DEF_N_TAPS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_MAX_ON_CYCLES   = 16;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    COOLDOWN
  } tap_state_t;

endpackage

// File: rtl/water_tap_scheduler_ir_debounce.sv
// One tap's IR input: 2-flop synchroniser followed by a consecutive-sample debouncer.
module ir_debounce
  import water_tap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_pin,
  output logic req
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive differing samples preceded this one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      req  <= 1'b0;
    end else begin
      sync <= {sync[0], ir_pin};
      if (sync[1] == req) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        req <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/water_tap_scheduler.sv
// Grants one shared pump to debounced tap requests in round-robin order,
// with a per-grant on-time limit, timeout lockout and a fixed cool-down gap.
module water_tap_scheduler
  import water_tap_pkg::*;
#(
  parameter int unsigned N_TAPS          = DEF_N_TAPS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_TAPS-1:0]         ir_pin,
  output logic [N_TAPS-1:0]         relay_out,
  output logic                      pump_on,
  output logic [$clog2(N_TAPS)-1:0] active_id,
  output logic                      timeout_pulse
);

  localparam int unsigned ID_W    = $clog2(N_TAPS);
  localparam int unsigned CNT_MAX = (MAX_ON_CYCLES > COOLDOWN_CYCLES) ? MAX_ON_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  tap_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ID_W-1:0]   last_grant, last_grant_next;
  logic [N_TAPS-1:0] req, lockout, lockout_next, lock_set, eligible;
  logic [ID_W-1:0]   pick;
  logic              pick_valid;
  logic              timed_out;

  logic [N_TAPS-1:0] relay_next;
  logic              pump_next;
  logic [ID_W-1:0]   id_next;
  logic              tpulse_next;

  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    ir_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .ir_pin(ir_pin[i]),
      .req   (req[i])
    );
  end

  assign eligible = req & ~lockout;

  // first eligible tap strictly after last_grant, wrapping
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= N_TAPS; k++) begin
      idx = (32'(last_grant) + k) % N_TAPS;
      if (!pick_valid && eligible[ID_W'(idx)]) begin
        pick_valid = 1'b1;
        pick       = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= ID_W'(N_TAPS - 1);
      lockout       <= '0;
      relay_out     <= '0;
      pump_on       <= 1'b0;
      active_id     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      last_grant    <= last_grant_next;
      lockout       <= lockout_next;
      relay_out     <= relay_next;
      pump_on       <= pump_next;
      active_id     <= id_next;
      timeout_pulse <= tpulse_next;
    end
  end

  // timeout takes precedence over a release landing on the same cycle
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    lock_set        = '0;
    timed_out       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next      = OPEN;
          last_grant_next = pick;
          cnt_next        = CNT_W'(1);
        end
      end
      OPEN: begin
        if (cnt == CNT_W'(MAX_ON_CYCLES)) begin
          timed_out            = 1'b1;
          lock_set[last_grant] = 1'b1;
          state_next           = COOLDOWN;
          cnt_next             = CNT_W'(1);
        end else if (!req[last_grant]) begin
          state_next = COOLDOWN;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt == CNT_W'(COOLDOWN_CYCLES)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    lockout_next = (lockout & req) | lock_set;
  end

  // outputs are computed from the next state so they come straight off flops
  always_comb begin
    relay_next  = '0;
    id_next     = '0;
    pump_next   = (state_next == OPEN);
    tpulse_next = timed_out;
    if (state_next == OPEN) begin
      relay_next[last_grant_next] = 1'b1;
      id_next                     = last_grant_next;
    end
  end

endmodule
